// File: rtl/k_vector_loader.sv
// ---------------------------------------------------------------------------
// k_vector_loader
//
// Loads the SHA-256 round-constant vector from an external K constant memory.
// A start pulse makes the loader walk addresses 0..K_LENGTH-1 and strobe reads.
// Each returned 32-bit word is stored bit-reversed into its slot of k_vector.
// The sticky k_vector_complete flag then stays high until the consumer
// releases it.
//
// Optional feature macro: K_PREFETCH_EN
//   defined   -> pipelined issue: reads go out on consecutive cycles and up to
//                READ_LATENCY reads are in flight.
//   undefined -> one read outstanding at a time (ISSUE -> WAIT -> ISSUE ...).
//
// Ports
//   clock             in   single clock, rising edge
//   reset             in   synchronous, active-high reset
//   start             in   begin a load (honoured in IDLE or DONE only)
//   vector_release    in   consumer acknowledge, clears completion in DONE
//                          (the natural name "release" is a reserved word in
//                          SystemVerilog)
//   k_read_en         out  read strobe to the K memory
//   k_address         out  word address to the K memory
//   k_data            in   read data from the K memory
//   busy              out  high in ISSUE / WAIT / DRAIN
//   k_vector_complete out  all words captured (sticky)
//   k_vector          out  assembled constants, word i at [32*i +: 32]
// ---------------------------------------------------------------------------
module k_vector_loader #(
    parameter int K_LENGTH        = 64,
    parameter int K_VECTOR_LENGTH = 2048,
    parameter int READ_LATENCY    = 1,
    localparam int AW = (K_LENGTH > 1) ? $clog2(K_LENGTH) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       vector_release,
    output logic                       k_read_en,
    output logic [AW-1:0]              k_address,
    input  logic [31:0]                k_data,
    output logic                       busy,
    output logic                       k_vector_complete,
    output logic [K_VECTOR_LENGTH-1:0] k_vector
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(K_LENGTH - 1);

    state_t                  state_reg;
    logic [AW-1:0]           cap_cnt_reg;
    // Bit n set means a read strobe was sampled n+1 edges ago.
    // The top bit therefore marks the edge at which k_data is valid.
    logic [READ_LATENCY-1:0] pipe_reg;
    logic                    capture;
    logic                    last_capture;
    logic [31:0]             k_data_rev;

    assign capture      = pipe_reg[READ_LATENCY-1];
    assign last_capture = capture && (cap_cnt_reg == LAST_ADDR);

    // Word bits are stored in reversed order: k_vector[32*i + j] = k_data[31 - j].
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rev
            assign k_data_rev[gi] = k_data[31 - gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            k_read_en         <= 1'b0;
            k_address         <= '0;
            busy              <= 1'b0;
            k_vector_complete <= 1'b0;
            k_vector          <= '0;
            cap_cnt_reg       <= '0;
            pipe_reg          <= '0;   // discards any reads still in flight
        end else begin
            // The strobe shifts in at the edge where the memory samples it.
            pipe_reg <= READ_LATENCY'({pipe_reg, k_read_en});

            if (capture) begin
                k_vector[32*int'(cap_cnt_reg) +: 32] <= k_data_rev;
                cap_cnt_reg <= cap_cnt_reg + AW'(1);
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        // Raise the first strobe right away.
                        // The memory then samples address 0 on the next edge.
                        state_reg         <= ISSUE;
                        k_read_en         <= 1'b1;
                        k_address         <= '0;
                        busy              <= 1'b1;
                        k_vector_complete <= 1'b0;
                        k_vector          <= '0;
                        cap_cnt_reg       <= '0;
                        pipe_reg          <= '0;
                    end else if (state_reg == DONE && vector_release) begin
                        state_reg         <= IDLE;
                        k_vector_complete <= 1'b0;
                    end
                end

                ISSUE: begin
`ifdef K_PREFETCH_EN
                    // Back-to-back strobes.
                    // The address stops at the last word and never wraps.
                    if (k_address == LAST_ADDR) begin
                        k_read_en <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        k_address <= k_address + AW'(1);
                    end
`else
                    // Single strobe, then wait for its data.
                    k_read_en <= 1'b0;
                    state_reg <= WAIT;
`endif
                end

                WAIT: begin
                    if (last_capture) begin
                        state_reg         <= DONE;
                        busy              <= 1'b0;
                        k_vector_complete <= 1'b1;
                    end else if (capture) begin
                        state_reg <= ISSUE;
                        k_read_en <= 1'b1;
                        k_address <= k_address + AW'(1);
                    end
                end

                DRAIN: begin
                    if (last_capture) begin
                        state_reg         <= DONE;
                        busy              <= 1'b0;
                        k_vector_complete <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    k_read_en <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k_vector_loader.sv
// ---------------------------------------------------------------------------
// tb_k_vector_loader
//
// Self-checking bench for k_vector_loader.
// Two instances are driven, both loading from a SHA-256 K ROM model:
//   - u_dut1 uses READ_LATENCY=1.
//   - u_dut3 uses READ_LATENCY=3.
// A table of load scenarios is applied in a loop.
// Hand-written sequences then cover release, start+release, and reset mid-load.
// Compile with +define+K_PREFETCH_EN to exercise the pipelined variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_k_vector_loader;

    localparam int BUDGET = 400;

`ifdef K_PREFETCH_EN
    localparam int LAT1 = 65;    // 64 + 1
    localparam int LAT3 = 67;    // 64 + 3
    localparam bit PREFETCH = 1'b1;
`else
    localparam int LAT1 = 128;   // 1 + 63*2 + 1
    localparam int LAT3 = 256;   // 1 + 63*4 + 3
    localparam bit PREFETCH = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start1 = 1'b0, start3 = 1'b0;
    logic          rel1 = 1'b0, rel3 = 1'b0;
    logic          en1, en3, busy1, busy3, done1, done3;
    logic [5:0]    addr1, addr3;
    logic [31:0]   data1, data3;
    logic [2047:0] vec1, vec3;

    int total = 0;
    int bad   = 0;

    logic [31:0] k_rom [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ROM models.
    // Data is valid exactly READ_LATENCY edges after the strobe is sampled.
    // Otherwise the ROM returns filler, so a capture on the wrong edge shows up.
    logic [31:0] rd3 [3];
    always @(posedge clk) data1 <= en1 ? k_rom[addr1] : 32'hdeadbeef;
    always @(posedge clk) begin
        rd3[0] <= en3 ? k_rom[addr3] : 32'hdeadbeef;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign data3 = rd3[2];

    k_vector_loader #(.K_LENGTH(64), .K_VECTOR_LENGTH(2048), .READ_LATENCY(1)) u_dut1 (
        .clock(clk), .reset(reset), .start(start1), .vector_release(rel1),
        .k_read_en(en1), .k_address(addr1), .k_data(data1),
        .busy(busy1), .k_vector_complete(done1), .k_vector(vec1)
    );

    k_vector_loader #(.K_LENGTH(64), .K_VECTOR_LENGTH(2048), .READ_LATENCY(3)) u_dut3 (
        .clock(clk), .reset(reset), .start(start3), .vector_release(rel3),
        .k_read_en(en3), .k_address(addr3), .k_data(data3),
        .busy(busy3), .k_vector_complete(done3), .k_vector(vec3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [2047:0] exp_vector();
        logic [2047:0] v;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++)
                v[32*i + j] = k_rom[i][31 - j];
        return v;
    endfunction

    // Number of 32-bit slots that differ from the fully loaded table.
    function automatic int word_errors(input logic [2047:0] v);
        logic [2047:0] e;
        int n;
        e = exp_vector();
        n = 0;
        for (int i = 0; i < 64; i++)
            if (v[32*i +: 32] !== e[32*i +: 32]) n++;
        return n;
    endfunction

    function automatic logic cur_en(input int sel);
        return (sel != 0) ? en3 : en1;
    endfunction
    function automatic logic [5:0] cur_addr(input int sel);
        return (sel != 0) ? addr3 : addr1;
    endfunction
    function automatic logic cur_done(input int sel);
        return (sel != 0) ? done3 : done1;
    endfunction
    function automatic logic cur_busy(input int sel);
        return (sel != 0) ? busy3 : busy1;
    endfunction
    function automatic logic [2047:0] cur_vec(input int sel);
        return (sel != 0) ? vec3 : vec1;
    endfunction

    task automatic drive_start(input int sel, input logic v);
        if (sel != 0) start3 = v;
        else          start1 = v;
    endtask

    // Pulse start, then count strobes and edges until completion.
    // restart_at >= 0 re-pulses start on the strobe carrying that address.
    task automatic run_load(input int sel, input int restart_at, input int exp_lat, input string tag);
        int  n, strobes, first, last;
        bit  seen;
        strobes = 0; first = -1; last = -1; seen = 1'b0;
        drive_start(sel, 1'b1);
        @(posedge clk); #1;
        drive_start(sel, 1'b0);
        for (n = 1; n <= BUDGET; n++) begin
            if (cur_en(sel)) begin
                strobes++;
                if (first < 0) first = n;
                last = n;
                if (restart_at >= 0 && int'(cur_addr(sel)) == restart_at)
                    drive_start(sel, 1'b1);
            end
            @(posedge clk); #1;
            drive_start(sel, 1'b0);
            if (cur_done(sel)) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " complete seen"}, 64'(seen), 64'd1);
        check({tag, " complete latency"}, 64'(n), 64'(exp_lat));
        check({tag, " strobe count"}, 64'(strobes), 64'd64);
        if (PREFETCH)
            check({tag, " strobe span"}, 64'(last - first + 1), 64'd64);
        check({tag, " busy after done"}, 64'(cur_busy(sel)), 64'd0);
    endtask

    typedef struct {
        int          sel;          // 0: latency-1 instance, 1: latency-3 instance
        int          restart_at;   // address at which start is re-pulsed, -1 none
        int          word_idx;     // slot checked against a hand-reversed value
        logic [31:0] word_exp;
    } vec_t;

    initial begin
        vec_t        tbl [4];
        logic [2047:0] v;
        int          n, strobes;
        bit          found;

        tbl[0] = '{sel: 1, restart_at: -1, word_idx: 1,  word_exp: 32'h8922ec8e};
        tbl[1] = '{sel: 1, restart_at: 10, word_idx: 0,  word_exp: 32'h19f45142};
        tbl[2] = '{sel: 0, restart_at: -1, word_idx: 0,  word_exp: 32'h19f45142};
        tbl[3] = '{sel: 0, restart_at: 10, word_idx: 63, word_exp: 32'h4f1e8e63};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset read_en",  64'(en1),   64'd0);
        check("reset address",  64'(addr1), 64'd0);
        check("reset busy",     64'(busy1), 64'd0);
        check("reset complete", 64'(done1), 64'd0);
        check("reset vector",   64'(vec1 != '0), 64'd0);
        check("reset complete rl3", 64'(done3), 64'd0);

        for (int k = 0; k < 4; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            run_load(tbl[k].sel, tbl[k].restart_at, (tbl[k].sel != 0) ? LAT3 : LAT1, tag);
            v = cur_vec(tbl[k].sel);
            check({tag, " word"}, 64'(v[32*tbl[k].word_idx +: 32]), 64'(tbl[k].word_exp));
            check({tag, " all words"}, 64'(word_errors(v)), 64'd0);
        end

        // The latency-1 instance is in DONE here. Release alone clears the flag.
        rel1 = 1'b1;
        @(posedge clk); #1;
        rel1 = 1'b0;
        check("release complete", 64'(done1), 64'd0);
        check("release vector kept", 64'(word_errors(vec1)), 64'd0);
        check("release busy", 64'(busy1), 64'd0);

        // Load again from IDLE to reach DONE.
        // Then start and release together: start wins.
        run_load(0, -1, LAT1, "reload");
        start1 = 1'b1; rel1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; rel1 = 1'b0;
        check("start+release complete", 64'(done1), 64'd0);
        check("start+release vector",   64'(vec1 != '0), 64'd0);
        check("start+release read_en",  64'(en1), 64'd1);
        check("start+release address",  64'(addr1), 64'd0);
        found = 1'b0;
        for (n = 0; n < BUDGET; n++) begin
            @(posedge clk); #1;
            if (done1) begin found = 1'b1; break; end
        end
        check("start+release finishes", 64'(found), 64'd1);
        check("start+release words", 64'(word_errors(vec1)), 64'd0);

        // Reset lands on the edge that samples read 20.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        found = 1'b0;
        for (n = 0; n < BUDGET; n++) begin
            if (en1 && addr1 == 6'd20) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("reach read 20", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset read_en",  64'(en1),   64'd0);
        check("midreset address",  64'(addr1), 64'd0);
        check("midreset busy",     64'(busy1), 64'd0);
        check("midreset complete", 64'(done1), 64'd0);
        check("midreset vector",   64'(vec1 != '0), 64'd0);
        strobes = 0;
        repeat (20) begin
            if (en1) strobes++;
            @(posedge clk); #1;
        end
        check("midreset no strobes", 64'(strobes), 64'd0);
        check("midreset no captures", 64'(vec1 != '0), 64'd0);
        check("midreset complete low", 64'(done1), 64'd0);
        run_load(0, -1, LAT1, "after reset");
        check("after reset words", 64'(word_errors(vec1)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
